// File: rtl/emu_run_ctrl.sv
// Run controller for the link emulator: staged reset release across N clock-enable
// domains, programmable stop time, per-domain enable counters; optional stall watchdog under EMU_WATCHDOG_EN.
module emu_run_ctrl #(
  parameter int unsigned N          = 3,
  parameter int unsigned TIME_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 32,
  parameter int unsigned WDOG_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [TIME_WIDTH-1:0]   time_stop,
  input  logic [TIME_WIDTH-1:0]   time_curr,
  input  logic [N-1:0]            cke,
  input  logic [WDOG_WIDTH-1:0]   wdog_limit,
  output logic                    sys_rst,
  output logic [N-1:0]            dom_rst,
  output logic [1:0]              state,
  output logic                    sim_done,
  output logic                    timeout,
  output logic [N*CNT_WIDTH-1:0]  cke_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [TIME_WIDTH-1:0] stop_q;
  logic [CNT_WIDTH-1:0]  cnt_q [N];
  logic                  stop_hit;
  logic                  wdog_trip;

  assign stop_hit = (time_curr >= stop_q);

`ifdef EMU_WATCHDOG_EN
  logic [TIME_WIDTH-1:0] time_prev;
  logic [WDOG_WIDTH-1:0] wdog_q;
  logic [WDOG_WIDTH:0]   wdog_inc;
  logic                  active;
  logic                  stall;
  logic                  timeout_q;

  assign active    = (state == ARM) || (state == RUN);
  assign stall     = (time_curr == time_prev);
  assign wdog_inc  = {1'b0, wdog_q} + (WDOG_WIDTH+1)'(1);
  // Trip on the stalled cycle that brings the count up to the limit.
  assign wdog_trip = active && stall && (wdog_limit != '0) &&
                     (wdog_inc >= {1'b0, wdog_limit});
  assign timeout   = timeout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      time_prev <= '0;
      wdog_q    <= '0;
    end else begin
      time_prev <= time_curr;
      if (abort || !active || !stall) begin
        wdog_q <= '0;
      end else if (wdog_q != '1) begin
        wdog_q <= wdog_inc[WDOG_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= timeout_q;
    end else if ((state == IDLE) && start) begin
      timeout_q <= 1'b0;
    end else if (wdog_trip && !((state == RUN) && stop_hit)) begin
      timeout_q <= 1'b1;
    end
  end
`else
  logic unused_wdog;

  assign unused_wdog = ^wdog_limit;
  assign wdog_trip   = 1'b0;
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sys_rst  <= 1'b1;
      dom_rst  <= '1;
      sim_done <= 1'b0;
      stop_q   <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else if (abort) begin
      state   <= IDLE;
      sys_rst <= 1'b1;
      dom_rst <= '1;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          sys_rst <= 1'b1;
          dom_rst <= '1;
          for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
          if (start) begin
            state    <= ARM;
            sys_rst  <= 1'b0;
            sim_done <= 1'b0;
            stop_q   <= time_stop;
          end
        end
        ARM: begin
          // Each domain leaves reset on its own first enable and stays out.
          dom_rst <= dom_rst & ~cke;
          if (wdog_trip) begin
            state    <= DONE;
            sim_done <= 1'b1;
          end else if (dom_rst == '0) begin
            state <= RUN;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < N; i++) begin
            if (cke[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
          end
          if (stop_hit || wdog_trip) begin
            state    <= DONE;
            sim_done <= 1'b1;
          end
        end
        DONE: begin
          if (start) begin
            state   <= IDLE;
            sys_rst <= 1'b1;
            dom_rst <= '1;
            for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cke_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cke_count[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

endmodule

// File: tb/tb_emu_run_ctrl.sv
// Directed bench for emu_run_ctrl (N=3, CNT_WIDTH=4 so saturation is reachable);
// watchdog expectations follow EMU_WATCHDOG_EN.
module tb_emu_run_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned TW = 32;
  localparam int unsigned CW = 4;
  localparam int unsigned WW = 24;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic           abort;
  logic [TW-1:0]  time_stop;
  logic [TW-1:0]  time_curr;
  logic [N-1:0]   cke;
  logic [WW-1:0]  wdog_limit;
  logic           sys_rst;
  logic [N-1:0]   dom_rst;
  logic [1:0]     state;
  logic           sim_done;
  logic           timeout;
  logic [N*CW-1:0] cke_count;

  int checks   = 0;
  int failures = 0;

  emu_run_ctrl #(
    .N(N), .TIME_WIDTH(TW), .CNT_WIDTH(CW), .WDOG_WIDTH(WW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .time_stop(time_stop), .time_curr(time_curr), .cke(cke),
    .wdog_limit(wdog_limit), .sys_rst(sys_rst), .dom_rst(dom_rst),
    .state(state), .sim_done(sim_done), .timeout(timeout),
    .cke_count(cke_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL sim_time_limit got=1 exp=0");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    time_stop = '0; time_curr = '0; cke = '0; wdog_limit = '0;
    step(); step();
    check_eq("rst_state", state, 0);
    check_eq("rst_sys_rst", sys_rst, 1);
    check_eq("rst_dom_rst", dom_rst, 7);
    check_eq("rst_sim_done", sim_done, 0);
    check_eq("rst_timeout", timeout, 0);
    check_eq("rst_counts", cke_count, 0);
    rst_n = 1'b1;
    step();

    // Release ordering: start in cycle 0, first enables at cycles 2, 5, 9.
    start = 1'b1; time_stop = 1000;
    step();
    start = 1'b0;
    check_eq("arm_state", state, 1);
    check_eq("arm_sys_rst", sys_rst, 0);
    check_eq("arm_dom_rst", dom_rst, 7);
    for (int c = 1; c <= 10; c++) begin
      logic [2:0] exp_rst;
      cke = (c == 2) ? 3'b100 : (c == 5) ? 3'b001 : (c == 9) ? 3'b010 :
            (c == 10) ? 3'b111 : 3'b000;
      step();
      exp_rst = 3'b111;
      if (c >= 2) exp_rst[2] = 1'b0;
      if (c >= 5) exp_rst[0] = 1'b0;
      if (c >= 9) exp_rst[1] = 1'b0;
      check_eq($sformatf("rel_dom_rst_c%0d", c), dom_rst, exp_rst);
      check_eq($sformatf("rel_state_c%0d", c), state, (c >= 10) ? 2 : 1);
    end
    check_eq("rel_counts_zero", cke_count, 0);

    // Counting and saturation over 20 RUN cycles.
    for (int j = 0; j < 20; j++) begin
      cke = {(j == 7), (j % 4 == 0), 1'b1};
      time_curr = j * 10;
      step();
    end
    check_eq("sat_cnt0", cke_count[3:0], 15);
    check_eq("sat_cnt1", cke_count[7:4], 5);
    check_eq("sat_cnt2", cke_count[11:8], 1);

    // Stop at time_curr = 1000.
    for (int v = 900; v <= 1000; v += 10) begin
      cke = 3'b100;
      time_curr = v;
      step();
      check_eq($sformatf("stop_done_%0d", v), sim_done, (v == 1000) ? 1 : 0);
      check_eq($sformatf("stop_state_%0d", v), state, (v == 1000) ? 3 : 2);
    end
    cke = 3'b111; time_curr = 1010; step();
    time_curr = 1020; step();
    check_eq("frz_cnt0", cke_count[3:0], 15);
    check_eq("frz_cnt1", cke_count[7:4], 5);
    check_eq("frz_cnt2", cke_count[11:8], 12);
    check_eq("frz_done", sim_done, 1);
    check_eq("frz_resets", {sys_rst, dom_rst}, 0);
    cke = '0;

    // Restart: DONE -> IDLE -> ARM with a new stop time.
    time_stop = 50;
    start = 1'b1; step(); start = 1'b0;
    check_eq("rs_idle_state", state, 0);
    check_eq("rs_idle_resets", {sys_rst, dom_rst}, 4'b1111);
    check_eq("rs_idle_counts", cke_count, 0);
    time_curr = 0;
    start = 1'b1; step(); start = 1'b0;
    check_eq("rs_arm_state", state, 1);
    check_eq("rs_arm_done", sim_done, 0);
    time_stop = 10; time_curr = 20; cke = 3'b111;
    step();
    check_eq("rs_dom_rst", dom_rst, 0);
    cke = '0; step();
    check_eq("rs_run", state, 2);
    step();
    check_eq("rs_latched_stop", state, 2);
    time_curr = 50; step();
    check_eq("rs_done_state", state, 3);
    check_eq("rs_done", sim_done, 1);

    // Abort and start together in RUN.
    time_stop = 1000; time_curr = 0;
    start = 1'b1; step();
    start = 1'b1; step(); start = 1'b0;
    cke = 3'b111; step(); cke = '0; step();
    check_eq("ab_run", state, 2);
    abort = 1'b1; start = 1'b1; step(); abort = 1'b0; start = 1'b0;
    check_eq("ab_state", state, 0);
    check_eq("ab_resets", {sys_rst, dom_rst}, 4'b1111);

    // rst_n low mid-ARM.
    start = 1'b1; step(); start = 1'b0;
    cke = 3'b001; step();
    check_eq("mr_dom_rst", dom_rst, 6);
    rst_n = 1'b0; cke = '0; step();
    check_eq("mr_state", state, 0);
    check_eq("mr_resets", {sys_rst, dom_rst}, 4'b1111);
    check_eq("mr_flags", {sim_done, timeout}, 0);
    check_eq("mr_counts", cke_count, 0);
    rst_n = 1'b1; step();

    // Stall with time_curr frozen in RUN.
    wdog_limit = 8; time_stop = 1000; time_curr = 0;
    start = 1'b1; step(); start = 1'b0;
    time_curr = 1; cke = 3'b111; step();
    time_curr = 2; cke = '0; step();
    check_eq("wd_run", state, 2);
    for (int s = 1; s <= 8; s++) begin
      step();
`ifdef EMU_WATCHDOG_EN
      check_eq($sformatf("wd_state_s%0d", s), state, (s == 8) ? 3 : 2);
      check_eq($sformatf("wd_timeout_s%0d", s), timeout, (s == 8) ? 1 : 0);
`else
      check_eq($sformatf("wd_state_s%0d", s), state, 2);
      check_eq($sformatf("wd_timeout_s%0d", s), timeout, 0);
`endif
    end
`ifdef EMU_WATCHDOG_EN
    check_eq("wd_done", sim_done, 1);
`else
    for (int s = 0; s < 4; s++) step();
    check_eq("wd_off_state", state, 2);
    check_eq("wd_off_timeout", timeout, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
